// File: rtl/rr_seq_pkg.sv
// Shared definitions for the register-register control sequencer:
// state encoding, opcode constants and IR field positions.
package rr_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_ERR
    } seq_state_t;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_SHR  = 5'b00111;
    localparam logic [4:0] OPC_SHRA = 5'b01000;
    localparam logic [4:0] OPC_SHL  = 5'b01001;
    localparam logic [4:0] OPC_ROR  = 5'b01010;
    localparam logic [4:0] OPC_ROL  = 5'b01011;
    localparam logic [4:0] OPC_MUL  = 5'b01110;
    localparam logic [4:0] OPC_DIV  = 5'b01111;

    function automatic logic is_basic_alu(input logic [4:0] opc);
        return (opc >= OPC_ADD) && (opc <= OPC_ROL);
    endfunction

endpackage

// File: rtl/rr_ir_decode.sv
// Combinational IR legality check and one-hot register select generation.
// Macro SEQ_MULDIV_EN makes mul/div legal opcodes.
module rr_ir_decode
    import rr_seq_pkg::*;
#(
    parameter int NREGS  = 16,
    parameter int RSEL_W = 4
) (
    input  logic [31:0]      ir,
    output logic [4:0]       opcode,
    output logic             legal,
    output logic             muldiv_op,
    output logic [NREGS-1:0] ra_sel,
    output logic [NREGS-1:0] rb_sel,
    output logic [NREGS-1:0] rc_sel
);

    localparam logic [RSEL_W:0] NREGS_L = (RSEL_W+1)'(NREGS);

    logic [RSEL_W-1:0] ra;
    logic [RSEL_W-1:0] rb;
    logic [RSEL_W-1:0] rc;
    logic              fields_ok;
    logic              opc_ok;
    logic              unused_ir_low;

    assign opcode        = ir[OPC_HI:OPC_LO];
    assign ra            = ir[RA_HI:RA_LO];
    assign rb            = ir[RB_HI:RB_LO];
    assign rc            = ir[RC_HI:RC_LO];
    assign unused_ir_low = ^ir[RC_LO-1:0];

    assign fields_ok = ({1'b0, ra} < NREGS_L) &&
                       ({1'b0, rb} < NREGS_L) &&
                       ({1'b0, rc} < NREGS_L);

`ifdef SEQ_MULDIV_EN
    assign muldiv_op = (opcode == OPC_MUL) || (opcode == OPC_DIV);
`else
    assign muldiv_op = 1'b0;
`endif

    assign opc_ok = is_basic_alu(opcode) || muldiv_op;
    assign legal  = opc_ok && fields_ok;

    // An out-of-range field matches no index, so its select stays all-zero.
    always_comb begin
        ra_sel = '0;
        rb_sel = '0;
        rc_sel = '0;
        for (int i = 0; i < NREGS; i++) begin
            ra_sel[i] = (ra == RSEL_W'(i));
            rb_sel[i] = (rb == RSEL_W'(i));
            rc_sel[i] = (rc == RSEL_W'(i));
        end
    end

endmodule

// File: rtl/rr_control_sequencer.sv
// Control sequencer for one register-register instruction (fetch T0..T2, execute T3..T5/T6).
// Macro SEQ_MULDIV_EN enables mul/div with the extra HI/LO writeback state T6.
module rr_control_sequencer
    import rr_seq_pkg::*;
#(
    parameter int NREGS  = 16,
    parameter int RSEL_W = 4
) (
    input  logic             Clock,
    input  logic             Clear_n,
    input  logic             start,
    input  logic [31:0]      IR,
    input  logic             mem_ready,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic [4:0]       alu_op,
    output logic             busy,
    output logic             done,
    output logic             err
);

    seq_state_t       state;
    seq_state_t       next_state;
    logic [4:0]       opcode;
    logic             legal;
    logic             muldiv_op;
    logic [NREGS-1:0] ra_sel;
    logic [NREGS-1:0] rb_sel;
    logic [NREGS-1:0] rc_sel;

    rr_ir_decode #(
        .NREGS  (NREGS),
        .RSEL_W (RSEL_W)
    ) u_decode (
        .ir        (IR),
        .opcode    (opcode),
        .legal     (legal),
        .muldiv_op (muldiv_op),
        .ra_sel    (ra_sel),
        .rb_sel    (rb_sel),
        .rc_sel    (rc_sel)
    );

    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs decode only the state register and IR, so reset clears them at once.
    always_comb begin
        next_state = state;
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        Zin        = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        Rin        = '0;
        Rout       = '0;
        alu_op     = 5'b00000;
        busy       = (state != ST_IDLE);
        done       = 1'b0;
        err        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_T0;
            end
            ST_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zin        = 1'b1;
                next_state = ST_T1;
            end
            ST_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (mem_ready) next_state = ST_T2;
            end
            ST_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                next_state = ST_T3;
            end
            ST_T3: begin
                if (legal) begin
                    Rout       = rb_sel;
                    Yin        = 1'b1;
                    next_state = ST_T4;
                end else begin
                    next_state = ST_ERR;
                end
            end
            ST_T4: begin
                Rout       = rc_sel;
                Zin        = 1'b1;
                alu_op     = opcode;
                next_state = ST_T5;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                // muldiv_op is tied low when mul/div support is compiled out.
                if (muldiv_op) begin
                    LOin       = 1'b1;
                    next_state = ST_T6;
                end else begin
                    Rin        = ra_sel;
                    done       = 1'b1;
                    next_state = ST_IDLE;
                end
            end
`ifdef SEQ_MULDIV_EN
            ST_T6: begin
                Zhighout   = 1'b1;
                HIin       = 1'b1;
                done       = 1'b1;
                next_state = ST_IDLE;
            end
`endif
            ST_ERR: begin
                err        = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_control_sequencer.sv
// Directed self-checking bench for rr_control_sequencer (NREGS=16 and NREGS=8 instances).
// Expectations follow SEQ_MULDIV_EN when it is defined for the build.
module tb_rr_control_sequencer;

    localparam logic [12:0] S_T0   = 13'h1E00;
    localparam logic [12:0] S_T1   = 13'h0180;
    localparam logic [12:0] S_T2   = 13'h0060;
    localparam logic [12:0] S_YIN  = 13'h0010;
    localparam logic [12:0] S_ZIN  = 13'h0200;
    localparam logic [12:0] S_ZLO  = 13'h0008;
    localparam logic [12:0] S_ZHI  = 13'h0004;
    localparam logic [12:0] S_HI   = 13'h0002;
    localparam logic [12:0] S_LO   = 13'h0001;
    localparam logic [12:0] S_NONE = 13'h0000;

    logic        Clock;
    logic        Clear_n;
    logic        start;
    logic [31:0] IR;
    logic        mem_ready;

    logic PCout, MARin, IncPC, Zin, Read, MDRin, MDRout, IRin, Yin;
    logic Zlowout, Zhighout, HIin, LOin, busy, done, err;
    logic [15:0] Rin, Rout;
    logic [4:0]  alu_op;

    logic PCout8, MARin8, IncPC8, Zin8, Read8, MDRin8, MDRout8, IRin8, Yin8;
    logic Zlowout8, Zhighout8, HIin8, LOin8, busy8, done8, err8;
    logic [7:0] Rin8, Rout8;
    logic [4:0] alu_op8;

    int total;
    int bad;

    rr_control_sequencer #(.NREGS(16), .RSEL_W(4)) dut (
        .Clock(Clock), .Clear_n(Clear_n), .start(start), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .busy(busy), .done(done), .err(err)
    );

    rr_control_sequencer #(.NREGS(8), .RSEL_W(4)) dut8 (
        .Clock(Clock), .Clear_n(Clear_n), .start(start), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout8), .MARin(MARin8), .IncPC(IncPC8), .Zin(Zin8), .Read(Read8),
        .MDRin(MDRin8), .MDRout(MDRout8), .IRin(IRin8), .Yin(Yin8), .Zlowout(Zlowout8),
        .Zhighout(Zhighout8), .HIin(HIin8), .LOin(LOin8), .Rin(Rin8), .Rout(Rout8),
        .alu_op(alu_op8), .busy(busy8), .done(done8), .err(err8)
    );

    wire [12:0] strb  = {PCout, MARin, IncPC, Zin, Read, MDRin, MDRout, IRin, Yin,
                         Zlowout, Zhighout, HIin, LOin};
    wire [12:0] strb8 = {PCout8, MARin8, IncPC8, Zin8, Read8, MDRin8, MDRout8, IRin8, Yin8,
                         Zlowout8, Zhighout8, HIin8, LOin8};
    wire [52:0] obs   = {strb, Rout, Rin, alu_op, done, err, busy};
    wire [36:0] obs8  = {strb8, Rout8, Rin8, alu_op8, done8, err8, busy8};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [52:0] pk(input logic [12:0] s, input logic [15:0] ro,
                                       input logic [15:0] ri, input logic [4:0] a,
                                       input logic d, input logic e, input logic b);
        return {s, ro, ri, a, d, e, b};
    endfunction

    function automatic logic [36:0] pk8(input logic [12:0] s, input logic [7:0] ro,
                                        input logic [7:0] ri, input logic [4:0] a,
                                        input logic d, input logic e, input logic b);
        return {s, ro, ri, a, d, e, b};
    endfunction

    // Leaves the caller on the falling edge of the T0 cycle.
    task automatic start_pulse;
        @(negedge Clock);
        start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
    endtask

    task automatic test_reset;
        Clear_n   = 1'b0;
        start     = 1'b1;
        IR        = 32'h28918000;
        mem_ready = 1'b1;
        #3;
        total++;
        if (obs !== 53'd0) begin
            bad++;
            $display("[TB] FAIL reset_async: got %h want 0", obs);
        end
        @(negedge Clock);
        @(negedge Clock);
        total++;
        if (obs !== 53'd0 || obs8 !== 37'd0) begin
            bad++;
            $display("[TB] FAIL reset_hold: got %h / %h want 0", obs, obs8);
        end
        start   = 1'b0;
        Clear_n = 1'b1;
        @(negedge Clock);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_add;
        logic [52:0] exp_tbl [7];
        exp_tbl[0] = pk(S_T0,  16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[1] = pk(S_T1,  16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[2] = pk(S_T2,  16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[3] = pk(S_YIN, 16'h0004, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[4] = pk(S_ZIN, 16'h0008, 16'h0, 5'b00101, 0, 0, 1);
        exp_tbl[5] = pk(S_ZLO, 16'h0, 16'h0002, 5'h00, 1, 0, 1);
        exp_tbl[6] = pk(S_NONE, 16'h0, 16'h0, 5'h00, 0, 0, 0);
        IR        = 32'h28918000;
        mem_ready = 1'b1;
        start_pulse();
        for (int c = 0; c < 7; c++) begin
            total++;
            if (obs !== exp_tbl[c]) begin
                bad++;
                $display("[TB] FAIL and_cycle%0d: got %h want %h", c, obs, exp_tbl[c]);
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_stall;
        logic [52:0] exp_tbl [10];
        int          read_cycles;
        exp_tbl[0] = pk(S_T0,  16'h0, 16'h0, 5'h00, 0, 0, 1);
        for (int c = 1; c <= 4; c++) exp_tbl[c] = pk(S_T1, 16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[5] = pk(S_T2,  16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[6] = pk(S_YIN, 16'h0004, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[7] = pk(S_ZIN, 16'h0008, 16'h0, 5'b00111, 0, 0, 1);
        exp_tbl[8] = pk(S_ZLO, 16'h0, 16'h0008, 5'h00, 1, 0, 1);
        exp_tbl[9] = pk(S_NONE, 16'h0, 16'h0, 5'h00, 0, 0, 0);
        read_cycles = 0;
        IR        = 32'h39918000;
        mem_ready = 1'b0;
        start_pulse();
        for (int c = 0; c < 10; c++) begin
            total++;
            if (obs !== exp_tbl[c]) begin
                bad++;
                $display("[TB] FAIL shr_stall_cycle%0d: got %h want %h", c, obs, exp_tbl[c]);
            end
            if (Read === 1'b1) read_cycles++;
            mem_ready = (c >= 4);
            @(negedge Clock);
        end
        mem_ready = 1'b1;
        total++;
        if (read_cycles != 4) begin
            bad++;
            $display("[TB] FAIL shr_read_len: got %0d want 4", read_cycles);
        end
    endtask

    task automatic test_illegal_opcode;
        logic [52:0] exp_tbl [6];
        logic        rin_seen;
        exp_tbl[0] = pk(S_T0, 16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[1] = pk(S_T1, 16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[2] = pk(S_T2, 16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[3] = pk(S_NONE, 16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[4] = pk(S_NONE, 16'h0, 16'h0, 5'h00, 0, 1, 1);
        exp_tbl[5] = pk(S_NONE, 16'h0, 16'h0, 5'h00, 0, 0, 0);
        rin_seen  = 1'b0;
        IR        = {5'b11111, 4'd1, 4'd2, 4'd3, 15'd0};
        start_pulse();
        for (int c = 0; c < 6; c++) begin
            total++;
            if (obs !== exp_tbl[c]) begin
                bad++;
                $display("[TB] FAIL illegal_cycle%0d: got %h want %h", c, obs, exp_tbl[c]);
            end
            if (Rin !== 16'h0) rin_seen = 1'b1;
            @(negedge Clock);
        end
        total++;
        if (rin_seen !== 1'b0) begin
            bad++;
            $display("[TB] FAIL illegal_rin: got %b want 0", rin_seen);
        end
    endtask

    task automatic test_nregs;
        logic [52:0] exp_tbl [7];
        exp_tbl[0] = pk(S_T0,  16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[1] = pk(S_T1,  16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[2] = pk(S_T2,  16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[3] = pk(S_YIN, 16'h0002, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[4] = pk(S_ZIN, 16'h0004, 16'h0, 5'b00011, 0, 0, 1);
        exp_tbl[5] = pk(S_ZLO, 16'h0, 16'h0200, 5'h00, 1, 0, 1);
        exp_tbl[6] = pk(S_NONE, 16'h0, 16'h0, 5'h00, 0, 0, 0);
        IR = {5'b00011, 4'd9, 4'd1, 4'd2, 15'd0};
        start_pulse();
        for (int c = 0; c < 7; c++) begin
            total++;
            if (obs !== exp_tbl[c]) begin
                bad++;
                $display("[TB] FAIL ra9_n16_cycle%0d: got %h want %h", c, obs, exp_tbl[c]);
            end
            if (c == 3) begin
                total++;
                if (obs8 !== pk8(S_NONE, 8'h0, 8'h0, 5'h00, 0, 0, 1)) begin
                    bad++;
                    $display("[TB] FAIL ra9_n8_t3: got %h want busy only", obs8);
                end
            end
            if (c == 4) begin
                total++;
                if (obs8 !== pk8(S_NONE, 8'h0, 8'h0, 5'h00, 0, 1, 1)) begin
                    bad++;
                    $display("[TB] FAIL ra9_n8_err: got %h want err", obs8);
                end
            end
            if (c == 5) begin
                total++;
                if (obs8 !== 37'd0) begin
                    bad++;
                    $display("[TB] FAIL ra9_n8_idle: got %h want 0", obs8);
                end
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_muldiv;
        logic [52:0] exp_tbl [8];
        int          n;
        exp_tbl[0] = pk(S_T0, 16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[1] = pk(S_T1, 16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[2] = pk(S_T2, 16'h0, 16'h0, 5'h00, 0, 0, 1);
`ifdef SEQ_MULDIV_EN
        n = 8;
        exp_tbl[3] = pk(S_YIN, 16'h0004, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[4] = pk(S_ZIN, 16'h0008, 16'h0, 5'b01110, 0, 0, 1);
        exp_tbl[5] = pk(S_ZLO | S_LO, 16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[6] = pk(S_ZHI | S_HI, 16'h0, 16'h0, 5'h00, 1, 0, 1);
        exp_tbl[7] = pk(S_NONE, 16'h0, 16'h0, 5'h00, 0, 0, 0);
`else
        n = 6;
        exp_tbl[3] = pk(S_NONE, 16'h0, 16'h0, 5'h00, 0, 0, 1);
        exp_tbl[4] = pk(S_NONE, 16'h0, 16'h0, 5'h00, 0, 1, 1);
        exp_tbl[5] = pk(S_NONE, 16'h0, 16'h0, 5'h00, 0, 0, 0);
        exp_tbl[6] = '0;
        exp_tbl[7] = '0;
`endif
        IR = {5'b01110, 4'd1, 4'd2, 4'd3, 15'd0};
        start_pulse();
        for (int c = 0; c < n; c++) begin
            total++;
            if (obs !== exp_tbl[c]) begin
                bad++;
                $display("[TB] FAIL mul_cycle%0d: got %h want %h", c, obs, exp_tbl[c]);
            end
            @(negedge Clock);
        end
    endtask

    task automatic test_back_to_back;
        IR        = 32'h28918000;
        mem_ready = 1'b1;
        @(negedge Clock);
        start = 1'b1;
        @(negedge Clock);
        for (int c = 0; c < 8; c++) begin
            if (c == 5) begin
                total++;
                if (obs !== pk(S_ZLO, 16'h0, 16'h0002, 5'h00, 1, 0, 1)) begin
                    bad++;
                    $display("[TB] FAIL b2b_done: got %h want T5", obs);
                end
            end
            if (c == 6) begin
                total++;
                if (obs !== 53'd0) begin
                    bad++;
                    $display("[TB] FAIL b2b_idle: got %h want 0", obs);
                end
            end
            if (c == 7) begin
                total++;
                if (obs !== pk(S_T0, 16'h0, 16'h0, 5'h00, 0, 0, 1)) begin
                    bad++;
                    $display("[TB] FAIL b2b_restart: got %h want T0", obs);
                end
            end
            if (c < 5 && c > 0) begin
                total++;
                if (strb === S_T0) begin
                    bad++;
                    $display("[TB] FAIL b2b_ignored_start_c%0d: got %h want not T0", c, strb);
                end
            end
            @(negedge Clock);
        end
        start = 1'b0;
        repeat (5) @(negedge Clock);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_drain: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        IR        = 32'h28918000;
        mem_ready = 1'b1;
        start_pulse();
        repeat (4) @(negedge Clock);
        total++;
        if (alu_op !== 5'b00101) begin
            bad++;
            $display("[TB] FAIL midrst_in_t4: got %b want 00101", alu_op);
        end
        #2 Clear_n = 1'b0;
        #1;
        total++;
        if (obs !== 53'd0 || obs8 !== 37'd0) begin
            bad++;
            $display("[TB] FAIL midrst_async: got %h / %h want 0", obs, obs8);
        end
        @(negedge Clock);
        total++;
        if (done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_flags: got done=%b err=%b want 0 0", done, err);
        end
        Clear_n = 1'b1;
        start_pulse();
        total++;
        if (obs !== pk(S_T0, 16'h0, 16'h0, 5'h00, 0, 0, 1)) begin
            bad++;
            $display("[TB] FAIL midrst_rerun_t0: got %h want T0", obs);
        end
        repeat (5) @(negedge Clock);
        total++;
        if (obs !== pk(S_ZLO, 16'h0, 16'h0002, 5'h00, 1, 0, 1)) begin
            bad++;
            $display("[TB] FAIL midrst_rerun_done: got %h want T5", obs);
        end
        @(negedge Clock);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_stall();
        test_illegal_opcode();
        test_nregs();
        test_muldiv();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_control_sequencer.md
RR_CONTROL_SEQUENCER -- requirements
Module: rr_control_sequencer

Interface
REQ-001 Parameter NREGS, default 16, meaning number of general registers; legal range 2..16.
REQ-002 Parameter RSEL_W, default 4, meaning width of each IR register field; fixed at 4.
REQ-003 Clock  in  1  single clock; all state changes on the rising edge.
REQ-004 Clear_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request to run one register-register instruction; sampled only in IDLE.
REQ-006 IR  in  32  instruction register contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-007 mem_ready  in  1  memory read acknowledge; T1 is held until mem_ready=1.
REQ-008 PCout, MARin, IncPC, Zin, Read, MDRin, MDRout, IRin, Yin, Zlowout, Zhighout, HIin, LOin  out  1 each  datapath strobes.
REQ-009 Rin, Rout  out  NREGS  one-hot register write and drive selects.
REQ-010 alu_op  out  5  ALU opcode; 5'b00000 when not in T4.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done, err  out  1 each  single-cycle completion and illegal-instruction flags.

Function
REQ-013 States: IDLE, T0, T1, T2, T3, T4, T5, T6, ERR; one state per clock except T1.
REQ-014 IDLE: all strobes 0; start=1 -> T0 next edge; start outside IDLE is ignored.
REQ-015 T0: PCout, MARin, IncPC, Zin = 1; -> T1.
REQ-016 T1: Read, MDRin = 1; mem_ready=0 -> stay in T1; mem_ready=1 -> T2.
REQ-017 T2: MDRout, IRin = 1; -> T3.
REQ-018 T3: decode IR; legal -> Rout[Rb], Yin = 1, -> T4; illegal -> all strobes 0, -> ERR.
REQ-019 T4: Rout[Rc], Zin = 1, alu_op = IR[31:27]; -> T5.
REQ-020 T5 (non-mul/div): Zlowout, Rin[Ra] = 1, done = 1; -> IDLE.
REQ-021 Legal opcodes: 5'b00011..5'b01011 inclusive (add, sub, and, or, shr, shra, shl, ror, rol), plus mul 5'b01110 and div 5'b01111 when REQ-029 applies.
REQ-022 Illegal instruction: any other opcode, or any of Ra/Rb/Rc >= NREGS.
REQ-023 ERR: err = 1 for exactly one cycle, no register written; -> IDLE.
REQ-024 Rin and Rout are one-hot or zero; never more than one bit set.
REQ-025 Strobes and flags are pure decode of the state register and IR; no strobe is asserted outside its listed state.
REQ-026 Latency with mem_ready tied to 1: start edge to done = 6 cycles (T0..T5); each stall cycle in T1 adds 1.

Reset
REQ-027 Clear_n=0 forces IDLE immediately, independent of Clock; every output is 0, including the one-hot selects and alu_op.
REQ-028 Reset mid-instruction aborts without done or err; the first start after Clear_n rises begins at T0.

Configuration
REQ-029 Macro SEQ_MULDIV_EN defined: mul/div are legal; T5 asserts Zlowout, LOin (no Rin, no done) -> T6; T6 asserts Zhighout, HIin, done -> IDLE.
REQ-030 Macro SEQ_MULDIV_EN undefined: T6 is absent; mul/div are illegal and take the ERR path.

Structure
REQ-031 Package rr_seq_pkg holds the state enum, the opcode constants, and the IR field bit positions.
REQ-032 One sub-module, rr_ir_decode: combinational legality check and Ra/Rb/Rc one-hot generation, parametrised by NREGS.

Verification
REQ-033 IR=32'h28918000, mem_ready=1, start pulse -> T3 Rout=16'h0004 with Yin; T4 Rout=16'h0008 with alu_op=5'b00101; T5 Rin=16'h0002 with done; 6 cycles total.
REQ-034 IR=32'h39918000 (shr R3,R2,R3), mem_ready low for 3 cycles in T1 -> Read held 4 cycles, done on cycle 9, alu_op=5'b00111 in T4.
REQ-035 IR opcode 5'b11111 -> err pulses once after T3, Rin never nonzero, busy drops the next cycle.
REQ-036 NREGS=8, IR Ra=4'd9 -> err; with NREGS=16 the same IR completes with Rin=16'h0200.
REQ-037 Opcode 5'b01110, macro defined -> T5 LOin, T6 HIin plus done, 7 cycles total; macro undefined -> err.
REQ-038 Clear_n pulsed low during T4 -> outputs 0 asynchronously, no done; next start re-runs from T0.
